int_arbiter: RTL and testbench

INT_ARBITER -- requirements
Module: int_arbiter

---
 rtl/int_arbiter_pkg.sv | 16 +
 rtl/int_arbiter_if.sv | 17 +
 rtl/int_prio_enc.sv | 15 +
 rtl/int_arbiter.sv | 73 +++++++
 tb/tb_int_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg: shared exception codes, vector indices and FSM encoding
package int_arbiter_pkg;
    localparam int INTOp_WIDTH = 2;
    typedef enum logic [INTOp_WIDTH-1:0] {
        INTOp_NONE = 2'd0,
        INTOp_TRAP = 2'd1,
        INTOp_SC   = 2'd2
    } intop_e;
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;
    localparam logic [4:0] VEC_TRAP = 5'd6;
    localparam logic [4:0] VEC_SC   = 5'd8;
    localparam logic [4:0] VEC_EXT  = 5'd16;
    function automatic logic [4:0] vec_id(intop_e op, logic [3:0] src);
        return op == INTOp_TRAP ? VEC_TRAP : op == INTOp_SC ? VEC_SC : VEC_EXT + {1'b0, src};
    endfunction
endpackage

// File: rtl/int_arbiter_if.sv
// int_arbiter_if: pipeline-side request/acknowledge handshake of the arbiter
interface int_arbiter_if
    import int_arbiter_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int SPR_WIDTH = 32
);
    intop_e                sync_op;
    logic [SPR_WIDTH-1:0]  IVPR;
    logic                  intAck;
    logic                  intReq;
    logic [PC_WIDTH-1:0]   intAddr;
    logic [4:0]            intId;
    logic                  intIsSync;
    modport master (input sync_op, IVPR, intAck, output intReq, intAddr, intId, intIsSync);
    modport slave  (output sync_op, IVPR, intAck, input intReq, intAddr, intId, intIsSync);
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder
module int_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = 4'(i);
    end
    assign valid = |req;
endmodule

// File: rtl/int_arbiter.sv
// int_arbiter: merges edge/level external interrupts with synchronous exceptions
// into a single held request with vector id and address.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 8,
    parameter int PC_WIDTH  = 32,
    parameter int SPR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] hw_int,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic               EE,
    int_arbiter_if.master      bus
);
    localparam int HW = PC_WIDTH / 2;

    state_e              state, state_nx;
    logic [NUM_SRC-1:0]  prev, pend, pend_nx, rise, cand, clr;
    logic                ext_v, take, ack, ext_q, sync_q, unused_ivpr_lo;
    logic [3:0]          ext_idx, src_q;
    logic [4:0]          id_nx, id_q;
    logic [PC_WIDTH-1:0] addr_nx, addr_q;

    int_prio_enc #(.N(NUM_SRC)) u_enc (.req(cand), .valid(ext_v), .idx(ext_idx));

    assign rise  = hw_int & ~prev;
    assign ack   = state == REQ && bus.intAck;
    assign clr   = (ack && ext_q) ? NUM_SRC'(1) << src_q : '0;
    // a fresh edge in the acknowledge cycle re-arms the source
    assign pend_nx = (edge_mode & (rise | (pend & ~clr))) | (~edge_mode & hw_int);
    assign cand  = pend & int_mask & {NUM_SRC{EE}};
    assign take  = state == IDLE && (bus.sync_op != INTOp_NONE || ext_v);
    assign id_nx = vec_id(bus.sync_op, ext_idx);
    assign addr_nx = PC_WIDTH'({bus.IVPR[SPR_WIDTH-1 -: SPR_WIDTH/2], HW'({id_nx, 4'h0})});
    assign unused_ivpr_lo = ^bus.IVPR[SPR_WIDTH/2-1:0];

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (take ? REQ : IDLE) : (bus.intAck ? IDLE : REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            prev   <= '0;
            pend   <= '0;
            id_q   <= '0;
            addr_q <= '0;
            sync_q <= 1'b0;
            ext_q  <= 1'b0;
            src_q  <= '0;
        end else begin
            state <= state_nx;
            prev  <= hw_int;
            pend  <= pend_nx;
            if (take) begin
                id_q   <= id_nx;
                addr_q <= addr_nx;
                sync_q <= bus.sync_op != INTOp_NONE;
                ext_q  <= bus.sync_op == INTOp_NONE;
                src_q  <= ext_idx;
            end
        end
    end

    assign bus.intReq    = state == REQ;
    assign bus.intAddr   = addr_q;
    assign bus.intId     = id_q;
    assign bus.intIsSync = sync_q;
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: vector table, directed corner sequences and randomized run
// against a cycle-level behavioural model of the arbiter.
module tb_int_arbiter;
    import int_arbiter_pkg::*;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] hw_int = '0;
    logic [N-1:0] edge_mode = '1;
    logic [N-1:0] int_mask = '1;
    logic         EE = 1'b1;
    int           checks = 0;
    int           errors = 0;

    int_arbiter_if #(.PC_WIDTH(32), .SPR_WIDTH(32)) bus ();

    int_arbiter #(.NUM_SRC(N), .PC_WIDTH(32), .SPR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .hw_int(hw_int), .edge_mode(edge_mode),
        .int_mask(int_mask), .EE(EE), .bus(bus.master)
    );

    always #5 clk = ~clk;

    bit           m_req, m_sync;
    logic [4:0]   m_id;
    logic [31:0]  m_addr;
    logic [N-1:0] m_pend, m_prev;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of the arbiter's rules, evaluated with the inputs seen at the edge.
    task automatic model_step();
        logic [N-1:0] cand, np;
        bit ack;
        if (rst) begin
            m_req = 0; m_sync = 0; m_id = 0; m_addr = 0; m_pend = 0; m_prev = 0;
            return;
        end
        ack = m_req && bus.intAck;
        for (int k = 0; k < N; k++)
            np[k] = edge_mode[k]
                ? ((hw_int[k] && !m_prev[k]) || (m_pend[k] && !(ack && !m_sync && m_id == 5'(16 + k))))
                : hw_int[k];
        cand = m_pend & int_mask & {N{EE}};
        if (!m_req && (bus.sync_op != INTOp_NONE || cand != 0)) begin
            m_req  = 1;
            m_sync = bus.sync_op != INTOp_NONE;
            if (bus.sync_op == INTOp_TRAP) m_id = 5'd6;
            else if (bus.sync_op == INTOp_SC) m_id = 5'd8;
            else for (int k = N - 1; k >= 0; k--) if (cand[k]) m_id = 5'(16 + k);
            m_addr = (bus.IVPR & 32'hFFFF_0000) | (32'(m_id) * 32'd16);
        end else if (ack) m_req = 0;
        m_pend = np;
        m_prev = hw_int;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_req", 32'(bus.intReq), 32'(m_req));
        if (m_req) begin
            chk("model_id", 32'(bus.intId), 32'(m_id));
            chk("model_sync", 32'(bus.intIsSync), 32'(m_sync));
            chk("model_addr", bus.intAddr, m_addr);
        end
    endtask

    task automatic chk_req(string name, logic req, logic [4:0] id);
        chk({name, "_req"}, 32'(bus.intReq), 32'(req));
        if (req) chk({name, "_id"}, 32'(bus.intId), 32'(id));
    endtask

    task automatic chk_zero(string name);
        chk({name, "_req"}, 32'(bus.intReq), 32'd0);
        chk({name, "_addr"}, bus.intAddr, 32'd0);
        chk({name, "_id"}, 32'(bus.intId), 32'd0);
        chk({name, "_sync"}, 32'(bus.intIsSync), 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] hw;
        intop_e       op;
        logic         ack;
        logic         req;
        logic [4:0]   id;
        logic         sync;
        logic [31:0]  addr;
    } vec_t;
    vec_t tbl[18];

    initial begin
        tbl[0]  = '{8'h00, INTOp_NONE, 0, 0, 5'd0,  0, 32'h0};
        tbl[1]  = '{8'h08, INTOp_NONE, 0, 0, 5'd0,  0, 32'h0};
        tbl[2]  = '{8'h00, INTOp_NONE, 0, 1, 5'd19, 0, 32'h1234_0130};
        tbl[3]  = '{8'h00, INTOp_NONE, 0, 1, 5'd19, 0, 32'h1234_0130};
        tbl[4]  = '{8'h00, INTOp_NONE, 1, 0, 5'd0,  0, 32'h0};
        tbl[5]  = '{8'h00, INTOp_NONE, 0, 0, 5'd0,  0, 32'h0};
        tbl[6]  = '{8'h01, INTOp_TRAP, 0, 1, 5'd6,  1, 32'h1234_0060};
        tbl[7]  = '{8'h01, INTOp_TRAP, 0, 1, 5'd6,  1, 32'h1234_0060};
        tbl[8]  = '{8'h01, INTOp_TRAP, 1, 0, 5'd0,  0, 32'h0};
        tbl[9]  = '{8'h00, INTOp_NONE, 0, 1, 5'd16, 0, 32'h1234_0100};
        tbl[10] = '{8'h00, INTOp_NONE, 1, 0, 5'd0,  0, 32'h0};
        tbl[11] = '{8'h00, INTOp_NONE, 0, 0, 5'd0,  0, 32'h0};
        tbl[12] = '{8'h20, INTOp_NONE, 0, 0, 5'd0,  0, 32'h0};
        tbl[13] = '{8'h00, INTOp_NONE, 0, 1, 5'd21, 0, 32'h1234_0150};
        tbl[14] = '{8'h20, INTOp_NONE, 1, 0, 5'd0,  0, 32'h0};
        tbl[15] = '{8'h20, INTOp_NONE, 0, 1, 5'd21, 0, 32'h1234_0150};
        tbl[16] = '{8'h20, INTOp_NONE, 1, 0, 5'd0,  0, 32'h0};
        tbl[17] = '{8'h00, INTOp_NONE, 0, 0, 5'd0,  0, 32'h0};

        bus.sync_op = INTOp_NONE;
        bus.IVPR    = 32'h1234_5678;
        bus.intAck  = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            hw_int      = tbl[i].hw;
            bus.sync_op = tbl[i].op;
            bus.intAck  = tbl[i].ack;
            tick();
            chk($sformatf("vec%0d_req", i), 32'(bus.intReq), 32'(tbl[i].req));
            if (tbl[i].req) begin
                chk($sformatf("vec%0d_id", i), 32'(bus.intId), 32'(tbl[i].id));
                chk($sformatf("vec%0d_sync", i), 32'(bus.intIsSync), 32'(tbl[i].sync));
                chk($sformatf("vec%0d_addr", i), bus.intAddr, tbl[i].addr);
            end
        end
        bus.sync_op = INTOp_NONE;
        bus.intAck  = 1'b0;

        // masked by EE: edge must stay pending until enabled
        EE = 1'b0; hw_int = 8'h04;
        tick();
        hw_int = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_req("ee_off", 1'b0, 5'd0);
        end
        EE = 1'b1;
        tick(); chk_req("ee_on", 1'b1, 5'd18);
        bus.intAck = 1'b1;
        tick(); chk_req("ee_ack", 1'b0, 5'd0);
        bus.intAck = 1'b0;
        tick(); chk_req("ee_idle", 1'b0, 5'd0);

        // level source reissues while held, stops once dropped
        edge_mode = 8'hFD; hw_int = 8'h02;
        tick(); chk_req("lvl_reg", 1'b0, 5'd0);
        tick(); chk_req("lvl_req", 1'b1, 5'd17);
        bus.intAck = 1'b1;
        tick(); chk_req("lvl_ack", 1'b0, 5'd0);
        bus.intAck = 1'b0;
        tick(); chk_req("lvl_reissue", 1'b1, 5'd17);
        bus.intAck = 1'b1; hw_int = 8'h00;
        tick(); chk_req("lvl_ack2", 1'b0, 5'd0);
        bus.intAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_req("lvl_dropped", 1'b0, 5'd0);
        end
        edge_mode = '1;

        // reset in the middle of a request with several sources pending
        hw_int = 8'h0F;
        tick(); chk_req("mid_pend", 1'b0, 5'd0);
        hw_int = 8'h00;
        tick(); chk_req("mid_req", 1'b1, 5'd16);
        rst = 1'b1;
        tick(); chk_zero("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_req("post_rst", 1'b0, 5'd0);
        end

        // input held high across reset release counts as an edge
        rst = 1'b1; hw_int = 8'h80;
        tick();
        rst = 1'b0;
        tick(); chk_req("held_edge", 1'b0, 5'd0);
        tick(); chk_req("held_req", 1'b1, 5'd23);
        bus.intAck = 1'b1; hw_int = 8'h00;
        tick();
        bus.intAck = 1'b0;

        for (int c = 0; c < 800; c++) begin
            hw_int = N'($urandom) & N'($urandom);
            if (c % 64 == 0) edge_mode = N'($urandom);
            int_mask    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            EE          = $urandom_range(0, 7) != 0;
            bus.sync_op = ($urandom_range(0, 9) == 0) ? intop_e'($urandom_range(1, 2)) : INTOp_NONE;
            bus.intAck  = $urandom_range(0, 2) == 0;
            rst         = $urandom_range(0, 199) == 0;
            if (c % 100 == 0) bus.IVPR = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
